// File: rtl/backprop_sequencer.sv
// backprop_sequencer: sequences one backward pass over backprop_stack, last layer down to layer 0
module backprop_sequencer #(
  parameter int max_layer_size = 4,
  parameter int data_size      = 8,
  parameter int size           = 3,
  parameter int index_size     = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [index_size-1:0] num_layers,
  input  logic                  abort,
  input  logic                  dc_dw_ready,
  output logic                  stack_clear,
  output logic [index_size-1:0] current_layer_index,
  output logic [index_size-1:0] dc_dw_layer_index,
  output logic                  cal_dy_dy_old,
  output logic                  copy,
  output logic                  dc_dw_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error
);
  typedef enum logic [2:0] {IDLE, CLEAR, CAL, COPY, DCDW, DONE} state_t;
  localparam logic [index_size-1:0] max_n = index_size'(max_layer_size);
  localparam logic [index_size-1:0] one = index_size'(1);
  state_t state, state_d;
  logic [index_size-1:0] l, l_d;
  logic err_d;
  logic start_ok;
  if (data_size < 1 || size < 1) begin : g_bad_params
  end
  assign start_ok = num_layers != '0 && num_layers <= max_n;
  // next state and layer counter; abort beats every other transition
  always_comb begin
    state_d = state;
    l_d = l;
    err_d = 1'b0;
    if (abort && state != IDLE) state_d = IDLE;
    else begin
      case (state)
        IDLE: if (start) begin
          state_d = start_ok ? CLEAR : IDLE;
          l_d = start_ok ? num_layers - one : l;
          err_d = !start_ok;
        end
        CLEAR: state_d = CAL;
        CAL: state_d = COPY;
        COPY: state_d = DCDW;
        DCDW: if (dc_dw_ready) begin
          state_d = l == '0 ? DONE : CAL;
          l_d = l == '0 ? l : l - one;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // state register with every output registered from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      l <= '0;
      stack_clear <= 1'b0;
      cal_dy_dy_old <= 1'b0;
      copy <= 1'b0;
      dc_dw_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_error <= 1'b0;
      current_layer_index <= '0;
      dc_dw_layer_index <= '0;
    end else begin
      state <= state_d;
      l <= l_d;
      stack_clear <= state_d == CLEAR;
      cal_dy_dy_old <= state_d == CAL;
      copy <= state_d == COPY;
      dc_dw_valid <= state_d == DCDW;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      cfg_error <= err_d;
      current_layer_index <= (state_d == CAL || state_d == COPY) ? l_d : current_layer_index;
      dc_dw_layer_index <= state_d == DCDW ? l_d : dc_dw_layer_index;
    end
  end
endmodule

// File: tb/tb_backprop_sequencer.sv
// tb_backprop_sequencer: directed and randomized passes checked against a per-cycle trace model
module tb_backprop_sequencer;
  localparam int W = 33;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, dc_dw_ready = 1'b0;
  logic [W-1:0] num_layers = '0;
  logic stack_clear, cal_dy_dy_old, copy, dc_dw_valid, busy, done, cfg_error;
  logic [W-1:0] current_layer_index, dc_dw_layer_index;
  typedef struct packed {
    logic clr, cal, cpy, vld, bsy, dn, err;
    logic [W-1:0] cur, dci;
  } obs_t;
  obs_t exp_q[$];
  int stall[4];
  logic [W-1:0] m_cur = '0, m_dci = '0;
  int checks = 0, failures = 0;

  backprop_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers), .abort(abort),
    .dc_dw_ready(dc_dw_ready), .stack_clear(stack_clear),
    .current_layer_index(current_layer_index), .dc_dw_layer_index(dc_dw_layer_index),
    .cal_dy_dy_old(cal_dy_dy_old), .copy(copy), .dc_dw_valid(dc_dw_valid), .busy(busy),
    .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {stack_clear, cal_dy_dy_old, copy, dc_dw_valid, busy, done, cfg_error,
            current_layer_index, dc_dw_layer_index};
  endfunction

  function automatic obs_t mk(input logic clr, cal, cpy, vld, bsy, dn, err,
                              input logic [W-1:0] cur, dci);
    return {clr, cal, cpy, vld, bsy, dn, err, cur, dci};
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // expected trace, one entry per cycle starting with the cycle after start is sampled
  task automatic build_pass(input int n);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, m_cur, m_dci));
    for (int k = n - 1; k >= 0; k--) begin
      m_cur = W'(k);
      exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0, m_cur, m_dci));
      exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 0, m_cur, m_dci));
      m_dci = W'(k);
      for (int s = 0; s <= stall[k]; s++) exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, m_cur, m_dci));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, m_cur, m_dci));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, m_cur, m_dci));
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s_idle%0d", tag, i), observe(), mk(0, 0, 0, 0, 0, 0, 0, m_cur, m_dci));
    end
  endtask

  task automatic run_pass(input int n, input bit disturb, input int abort_at, input int reset_at,
                          input string tag);
    int sz;
    build_pass(n);
    sz = exp_q.size();
    @(negedge clk);
    start = 1'b1;
    num_layers = W'(n);
    abort = 1'b0;
    dc_dw_ready = disturb;
    for (int j = 0; j < sz; j++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, j), observe(), exp_q[j]);
      start = (disturb && j < sz - 1) ? 1'($urandom) : 1'b0;
      num_layers = disturb ? W'($urandom_range(0, 7)) : W'(n);
      dc_dw_ready = exp_q[j].vld ? (j + 1 < sz && !exp_q[j + 1].vld)
                                 : (disturb && j < sz - 1 ? 1'($urandom) : 1'b0);
      if (j == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        dc_dw_ready = 1'b0;
        m_cur = exp_q[j].cur;
        m_dci = exp_q[j].dci;
        chk($sformatf("%s_abort", tag), observe(), mk(0, 0, 0, 0, 0, 0, 0, m_cur, m_dci));
        break;
      end
      if (j == reset_at) begin
        #2 reset = 1'b0;
        #1;
        m_cur = '0;
        m_dci = '0;
        chk($sformatf("%s_async_rst", tag), observe(), mk(0, 0, 0, 0, 0, 0, 0, '0, '0));
        start = 1'b0;
        dc_dw_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_rst_held", tag), observe(), mk(0, 0, 0, 0, 0, 0, 0, '0, '0));
        reset = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    dc_dw_ready = 1'b0;
  endtask

  task automatic reject(input logic [W-1:0] n, input string tag);
    @(negedge clk);
    start = 1'b1;
    num_layers = n;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_err", tag), observe(), mk(0, 0, 0, 0, 0, 0, 1, m_cur, m_dci));
    idle_check(2, tag);
  endtask

  initial begin
    #1 chk("reset_state", observe(), mk(0, 0, 0, 0, 0, 0, 0, '0, '0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_check(2, "after_reset");
    stall = '{0, 0, 0, 0};
    run_pass(3, 1'b0, -1, -1, "n3");
    stall = '{0, 4, 0, 0};
    run_pass(2, 1'b0, -1, -1, "n2_stall");
    reject('0, "rej0");
    reject(W'(5), "rej5");
    reject({1'b1, 32'd2}, "rej_big");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", observe(), mk(0, 0, 0, 0, 0, 0, 0, m_cur, m_dci));
    stall = '{0, 0, 0, 0};
    run_pass(4, 1'b0, 4, -1, "abort_cal2");
    idle_check(3, "post_abort");
    run_pass(1, 1'b0, -1, -1, "n1_after_abort");
    run_pass(3, 1'b1, -1, -1, "disturbed");
    run_pass(3, 1'b0, -1, 3, "rst_dcdw");
    idle_check(3, "post_rst");
    for (int p = 0; p < 12; p++) begin
      int n, sz, ab;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) stall[k] = int'($urandom_range(0, 3));
      sz = 3 + 3 * n;
      for (int k = 0; k < n; k++) sz += stall[k];
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, sz - 2)) : -1;
      run_pass(n, 1'($urandom), ab, -1, $sformatf("rand%0d", p));
      if (ab >= 0) idle_check(1, $sformatf("rand%0d", p));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
